// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: field/immediate decode, register file, load-use hazard, ID/EX latch
//
// Ports:
//   clk, reset            pipeline clock, asynchronous active-high reset
//   if_ir, if_pc          instruction word and its word address from IF/ID
//   branch_cond           taken branch from EX/MEM; flushes this stage
//   wb_en, wb_rd, wb_data register-file write port from MEM/WB
//   hazard                combinational load-use stall request to fetch
//   id_ex_*               registered ID/EX latch (valid = 0 marks a bubble)
//   bubble_count          saturating count of load-use bubbles inserted
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_ir,
  input  logic [31:0]     if_pc,
  input  logic            branch_cond,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard,
  output logic            id_ex_valid,
  output logic [31:0]     id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_val,
  output logic [XLEN-1:0] id_ex_rs2_val,
  output logic [31:0]     id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [6:0]      id_ex_opcode,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic            id_ex_alu_src,
  output logic            id_ex_illegal,
  output logic [15:0]     bubble_count
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Field extraction
  logic [4:0] rs1, rs2, rd;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;

  assign rs1      = if_ir[19:15];
  assign rs2      = if_ir[24:20];
  assign rd       = if_ir[11:7];
  assign opcode   = if_ir[6:0];
  assign funct3   = if_ir[14:12];
  assign funct7b5 = if_ir[30];

  // Opcode classification
  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr, legal;

  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_br    = 1'b0;
    is_lui   = 1'b0;
    is_auipc = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    case (opcode)
      OP_REG:    is_r     = 1'b1;
      OP_IMM:    is_i     = 1'b1;
      OP_LOAD:   is_ld    = 1'b1;
      OP_STORE:  is_st    = 1'b1;
      OP_BRANCH: is_br    = 1'b1;
      OP_LUI:    is_lui   = 1'b1;
      OP_AUIPC:  is_auipc = 1'b1;
      OP_JAL:    is_jal   = 1'b1;
      OP_JALR:   is_jalr  = 1'b1;
      default:   ;
    endcase
  end

  assign legal = is_r | is_i | is_ld | is_st | is_br | is_lui | is_auipc | is_jal | is_jalr;

  // Immediate generation; R-type and unknown opcodes carry no immediate
  logic [31:0] imm;

  always_comb begin
    imm = 32'd0;
    if (is_i || is_ld || is_jalr)
      imm = {{20{if_ir[31]}}, if_ir[31:20]};
    else if (is_st)
      imm = {{20{if_ir[31]}}, if_ir[31:25], if_ir[11:7]};
    else if (is_br)
      imm = {{19{if_ir[31]}}, if_ir[31], if_ir[7], if_ir[30:25], if_ir[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm = {if_ir[31:12], 12'd0};
    else if (is_jal)
      imm = {{11{if_ir[31]}}, if_ir[31], if_ir[19:12], if_ir[20], if_ir[30:21], 1'b0};
  end

  // Control bits; all zero for unknown opcodes since no class flag is set
  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_alu_src;
  logic uses_rs1, uses_rs2;

  assign dec_reg_write = (is_r | is_i | is_ld | is_lui | is_auipc | is_jal | is_jalr) && (rd != 5'd0);
  assign dec_mem_read  = is_ld;
  assign dec_mem_write = is_st;
  assign dec_branch    = is_br;
  assign dec_jump      = is_jal | is_jalr;
  assign dec_alu_src   = is_i | is_ld | is_st | is_lui | is_auipc | is_jal | is_jalr;
  assign uses_rs1      = is_r | is_i | is_ld | is_jalr | is_st | is_br;
  assign uses_rs2      = is_r | is_st | is_br;

  // Register file: x0 is never written and always reads as zero
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            wb_fire;

  assign wb_fire = wb_en && (wb_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_fire) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Write-through bypass so a same-cycle writeback is seen by this decode
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wb_fire && wb_rd == rs1) ? wb_data : regs_q[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_fire && wb_rd == rs2) ? wb_data : regs_q[rs2];
  end

  // ID/EX latch
  logic            valid_q, valid_d;
  logic [31:0]     pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7b5_q, funct7b5_d;
  logic            reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic            branch_q, branch_d, jump_q, jump_d, alu_src_q, alu_src_d, illegal_q, illegal_d;
  logic [15:0]     bubble_count_q, bubble_count_d;

  // A branch flush squashes the instruction in ID, so it cannot stall
  assign hazard = valid_q && mem_read_q && (rd_q != 5'd0) &&
                  ((rd_q == rs1 && uses_rs1) || (rd_q == rs2 && uses_rs2)) &&
                  !branch_cond;

  always_comb begin
    // Data fields always follow the decode; bubbles are marked by valid = 0
    pc_d           = if_pc;
    imm_d          = imm;
    rs1_val_d      = rs1_val;
    rs2_val_d      = rs2_val;
    rs1_d          = rs1;
    rs2_d          = rs2;
    rd_d           = rd;
    opcode_d       = opcode;
    funct3_d       = funct3;
    funct7b5_d     = funct7b5;
    valid_d        = 1'b1;
    reg_write_d    = dec_reg_write;
    mem_read_d     = dec_mem_read;
    mem_write_d    = dec_mem_write;
    branch_d       = dec_branch;
    jump_d         = dec_jump;
    alu_src_d      = dec_alu_src;
    illegal_d      = !legal;
    bubble_count_d = bubble_count_q;
    if (branch_cond || hazard) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      jump_d      = 1'b0;
      alu_src_d   = 1'b0;
      illegal_d   = 1'b0;
      if (!branch_cond && bubble_count_q != 16'hFFFF)
        bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= 1'b0;
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_val_q      <= '0;
      rs2_val_q      <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      opcode_q       <= '0;
      funct3_q       <= '0;
      funct7b5_q     <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
      alu_src_q      <= 1'b0;
      illegal_q      <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      rs1_val_q      <= rs1_val_d;
      rs2_val_q      <= rs2_val_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      opcode_q       <= opcode_d;
      funct3_q       <= funct3_d;
      funct7b5_q     <= funct7b5_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      branch_q       <= branch_d;
      jump_q         <= jump_d;
      alu_src_q      <= alu_src_d;
      illegal_q      <= illegal_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign id_ex_valid     = valid_q;
  assign id_ex_pc        = pc_q;
  assign id_ex_imm       = imm_q;
  assign id_ex_rs1_val   = rs1_val_q;
  assign id_ex_rs2_val   = rs2_val_q;
  assign id_ex_rs1       = rs1_q;
  assign id_ex_rs2       = rs2_q;
  assign id_ex_rd        = rd_q;
  assign id_ex_opcode    = opcode_q;
  assign id_ex_funct3    = funct3_q;
  assign id_ex_funct7b5  = funct7b5_q;
  assign id_ex_reg_write = reg_write_q;
  assign id_ex_mem_read  = mem_read_q;
  assign id_ex_mem_write = mem_write_q;
  assign id_ex_branch    = branch_q;
  assign id_ex_jump      = jump_q;
  assign id_ex_alu_src   = alu_src_q;
  assign id_ex_illegal   = illegal_q;
  assign bubble_count    = bubble_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_ir, if_pc;
  logic        branch_cond, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        hazard, id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [6:0]  id_ex_opcode;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_branch, id_ex_jump, id_ex_alu_src, id_ex_illegal;
  logic [15:0] bubble_count;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_ir(if_ir), .if_pc(if_pc),
    .branch_cond(branch_cond), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard(hazard), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val), .id_ex_imm(id_ex_imm),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_opcode(id_ex_opcode), .id_ex_funct3(id_ex_funct3), .id_ex_funct7b5(id_ex_funct7b5),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_illegal(id_ex_illegal), .bubble_count(bubble_count)
  );

  // Control bundle order: reg_write, mem_read, mem_write, branch, jump, alu_src, illegal
  localparam logic [6:0] C_RW = 7'b1000000;
  localparam logic [6:0] C_MR = 7'b0100000;
  localparam logic [6:0] C_MW = 7'b0010000;
  localparam logic [6:0] C_BR = 7'b0001000;
  localparam logic [6:0] C_JP = 7'b0000100;
  localparam logic [6:0] C_AS = 7'b0000010;
  localparam logic [6:0] C_IL = 7'b0000001;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm;
    logic [6:0]  ctl;
  } vec_t;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc, imm, r1v, r2v;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, ctl;
    logic [15:0] bcnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_cnt = 32'd100;
  logic [15:0] exp_bcnt = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [6:0] dut_ctl();
    return {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
            id_ex_jump, id_ex_alu_src, id_ex_illegal};
  endfunction

  function automatic exp_t mk(input string tag, input logic v, input logic [31:0] ir,
                              input logic [31:0] imm, input logic [6:0] ctl,
                              input logic [31:0] r1v, input logic [31:0] r2v);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = pc_cnt; e.imm = imm; e.ctl = v ? ctl : 7'd0;
    e.r1v = r1v; e.r2v = r2v; e.bcnt = exp_bcnt;
    e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.rd = ir[11:7]; e.opcode = ir[6:0];
    return e;
  endfunction

  // Advance one edge and compare the ID/EX latch against the oldest expectation
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty actual=0 required=1");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".valid"}, {31'd0, id_ex_valid}, {31'd0, e.valid});
      check({e.tag, ".ctl"}, {25'd0, dut_ctl()}, {25'd0, e.ctl});
      check({e.tag, ".bubble_count"}, {16'd0, bubble_count}, {16'd0, e.bcnt});
      if (e.valid) begin
        check({e.tag, ".pc"}, id_ex_pc, e.pc);
        check({e.tag, ".imm"}, id_ex_imm, e.imm);
        check({e.tag, ".rd"}, {27'd0, id_ex_rd}, {27'd0, e.rd});
        check({e.tag, ".rs1"}, {27'd0, id_ex_rs1}, {27'd0, e.rs1});
        check({e.tag, ".rs2"}, {27'd0, id_ex_rs2}, {27'd0, e.rs2});
        check({e.tag, ".opcode"}, {25'd0, id_ex_opcode}, {25'd0, e.opcode});
        check({e.tag, ".rs1_val"}, id_ex_rs1_val, e.r1v);
        check({e.tag, ".rs2_val"}, id_ex_rs2_val, e.r2v);
      end
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] imm,
                       input logic [6:0] ctl, input logic [31:0] r1v, input logic [31:0] r2v);
    if_ir = ir;
    if_pc = pc_cnt;
    sb_q.push_back(mk(tag, 1'b1, ir, imm, ctl, r1v, r2v));
    #1;
    check({tag, ".hazard"}, {31'd0, hazard}, 32'd0);
    tick();
    pc_cnt = pc_cnt + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[12];
    vt[0]  = '{32'h00500093, 32'h00000005, C_RW | C_AS};          // addi x1,x0,5
    vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, C_BR};                 // beq x0,x0,-4
    vt[2]  = '{32'h800000EF, 32'hFFF00000, C_RW | C_JP | C_AS};   // jal x1,min
    vt[3]  = '{32'hFFFFF0B7, 32'hFFFFF000, C_RW | C_AS};          // lui x1
    vt[4]  = '{32'h0000007F, 32'h00000000, C_IL};                 // unknown opcode
    vt[5]  = '{32'h002082B3, 32'h00000000, C_RW};                 // add x5,x1,x2
    vt[6]  = '{32'h00302023, 32'h00000000, C_MW | C_AS};          // sw x3,0(x0)
    vt[7]  = '{32'h00000013, 32'h00000000, C_AS};                 // addi x0,x0,0
    vt[8]  = '{32'h00002103, 32'h00000000, C_RW | C_MR | C_AS};   // lw x2,0(x0)
    vt[9]  = '{32'h12345397, 32'h12345000, C_RW | C_AS};          // auipc x7
    vt[10] = '{32'hFFF280E7, 32'hFFFFFFFF, C_RW | C_JP | C_AS};   // jalr x1,-1(x5)
    vt[11] = '{32'hFE20AC23, 32'hFFFFFFF8, C_MW | C_AS};          // sw x2,-8(x1)

    reset = 1'b1; if_ir = 32'd0; if_pc = 32'd0; branch_cond = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #1;
    check("reset.valid", {31'd0, id_ex_valid}, 32'd0);
    check("reset.hazard", {31'd0, hazard}, 32'd0);
    check("reset.pc", id_ex_pc, 32'd0);
    check("reset.imm", id_ex_imm, 32'd0);
    check("reset.ctl", {25'd0, dut_ctl()}, 32'd0);
    check("reset.bubble_count", {16'd0, bubble_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      issue($sformatf("vec%0d", i), vt[i].ir, vt[i].imm, vt[i].ctl, 32'd0, 32'd0);

    // Same-cycle writeback bypass into a store, then the committed value from the array
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    issue("bypass_sw", 32'h00302023, 32'd0, C_MW | C_AS, 32'd0, 32'hDEADBEEF);
    wb_en = 1'b0;
    issue("commit_sw", 32'h00302023, 32'd0, C_MW | C_AS, 32'd0, 32'hDEADBEEF);

    // Load-use: exactly one bubble, then the dependent addi
    issue("lu_lw", 32'h00002103, 32'd0, C_RW | C_MR | C_AS, 32'd0, 32'd0);
    if_ir = 32'h00110193;
    if_pc = pc_cnt;
    #1;
    check("lu.hazard_on", {31'd0, hazard}, 32'd1);
    exp_bcnt = exp_bcnt + 16'd1;
    sb_q.push_back(mk("lu_bubble", 1'b0, if_ir, 32'd0, 7'd0, 32'd0, 32'd0));
    tick();
    check("lu.hazard_off", {31'd0, hazard}, 32'd0);
    sb_q.push_back(mk("lu_addi", 1'b1, if_ir, 32'd1, C_RW | C_AS, 32'd0, 32'd0));
    tick();
    pc_cnt = pc_cnt + 32'd1;

    // Flush in the same cycle a load-use stall would be raised
    issue("fl_lw", 32'h00002103, 32'd0, C_RW | C_MR | C_AS, 32'd0, 32'd0);
    if_ir = 32'h00110193;
    if_pc = pc_cnt;
    branch_cond = 1'b1;
    #1;
    check("flush.hazard", {31'd0, hazard}, 32'd0);
    sb_q.push_back(mk("fl_bubble", 1'b0, if_ir, 32'd0, 7'd0, 32'd0, 32'd0));
    tick();
    branch_cond = 1'b0;
    issue("fl_addi", 32'h00110193, 32'd1, C_RW | C_AS, 32'd0, 32'd0);

    // x0 is never written, even with wb_en
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h00001234;
    issue("x0_bypass", 32'h00000293, 32'd0, C_RW | C_AS, 32'd0, 32'd0);
    wb_en = 1'b0;
    issue("x0_read", 32'h00000293, 32'd0, C_RW | C_AS, 32'd0, 32'd0);

    // add x6,x1,x3: x1 via bypass, x3 from the array, then both from the array
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h00001234;
    issue("rr_bypass", 32'h00308333, 32'd0, C_RW, 32'h00001234, 32'hDEADBEEF);
    wb_en = 1'b0;
    issue("rr_array", 32'h00308333, 32'd0, C_RW, 32'h00001234, 32'hDEADBEEF);

    // Asynchronous reset between edges clears the latch and the register file
    #2;
    reset = 1'b1;
    #1;
    check("areset.valid", {31'd0, id_ex_valid}, 32'd0);
    check("areset.pc", id_ex_pc, 32'd0);
    check("areset.rd", {27'd0, id_ex_rd}, 32'd0);
    check("areset.ctl", {25'd0, dut_ctl()}, 32'd0);
    check("areset.bubble_count", {16'd0, bubble_count}, 32'd0);
    check("areset.rs1_val", id_ex_rs1_val, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_bcnt = 16'd0;
    issue("post_reset_sw", 32'h00302023, 32'd0, C_MW | C_AS, 32'd0, 32'd0);

    check("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
